// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared width default and FSM state encoding for the bit-serial adder.
package serial_adder_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start handshake, operands and registered results of the bit-serial adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_fulladd.sv
// serial_adder_fulladd: 1-bit full-adder cell, the addition twin of the subtractor cell.
module serial_adder_fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder processing one bit per clock through a single full-adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, sum_q;
    logic [WIDTH-2:0] ss;
    logic             c, fs, fc, run, last, done_q, cout_q, ovf_q;

    assign run  = state == RUN;
    assign last = cnt == CW'(WIDTH - 1);

    always_comb begin
        nxt = IDLE;
        nxt = run ? (last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    serial_adder_fulladd fa (.a(sa[0]), .b(sb[0]), .cin(c), .sum(fs), .cout(fc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            ss     <= '0;
            c      <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= run && last;
            if (!run && bus.start) begin
                sa  <= bus.a;
                sb  <= bus.b;
                c   <= bus.cin;
                cnt <= '0;
            end else if (run) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                ss  <= (WIDTH-1)'({fs, ss} >> 1);
                c   <= fc;
                cnt <= cnt + CW'(1);
            end
            // c holds the carry into the MSB while the last bit is processed
            if (run && last) begin
                sum_q  <= {fs, ss};
                cout_q <= fc;
                ovf_q  <= c ^ fc;
            end
        end
    end

    assign bus.busy = run;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of 32-bit and 8-bit serial adders against a cycle-count model.
module tb_serial_adder;
    logic        clk, rst_n;
    logic        st[2], ci[2];
    logic [31:0] av[2], bv[2];
    logic        bsy[2], dn[2], co[2], ov[2];
    logic [31:0] sm[2];
    int          w[2] = '{32, 8};
    int          checks = 0, errors = 0;

    int          pend[2];
    logic        edn[2], rc[2], ro[2];
    logic [31:0] rs[2];
    logic [33:0] exp_r[2];

    genvar g;
    for (g = 0; g < 2; g++) begin : u
        localparam int W = (g == 0) ? 32 : 8;
        serial_adder_if #(.WIDTH(W)) bus ();
        assign bus.start = st[g];
        assign bus.a     = av[g][W-1:0];
        assign bus.b     = bv[g][W-1:0];
        assign bus.cin   = ci[g];
        assign bsy[g]    = bus.busy;
        assign dn[g]     = bus.done;
        assign sm[g]     = 32'(bus.sum);
        assign co[g]     = bus.cout;
        assign ov[g]     = bus.ovf;
        serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    always #5 clk = ~clk;

    function automatic logic [33:0] ref_add(int wd, logic [31:0] x, logic [31:0] y, logic c);
        logic [31:0] m, s;
        logic [32:0] f;
        m = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
        f = {1'b0, x & m} + {1'b0, y & m} + {32'd0, c};
        s = f[31:0] & m;
        return {(x[wd-1] == y[wd-1]) && (s[wd-1] != x[wd-1]), f[wd], s};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // an accepted start finishes exactly w cycles later; results hold until then
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] <= 0;
                edn[i]  <= 1'b0;
                rs[i]   <= '0;
                rc[i]   <= 1'b0;
                ro[i]   <= 1'b0;
                exp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                edn[i] <= pend[i] == 1;
                if (pend[i] == 1) {ro[i], rc[i], rs[i]} <= exp_r[i];
                if (st[i] && pend[i] == 0) begin
                    pend[i]  <= w[i];
                    exp_r[i] <= ref_add(w[i], av[i], bv[i], ci[i]);
                end else if (pend[i] != 0) pend[i] <= pend[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("busy", 32'(bsy[i]), 32'(pend[i] != 0));
            chk("done", 32'(dn[i]), 32'(edn[i]));
            chk("sum_reg", sm[i], rs[i]);
            chk("cout_reg", 32'(co[i]), 32'(rc[i]));
            chk("ovf_reg", 32'(ov[i]), 32'(ro[i]));
        end
    end

    task automatic wait_done(input int i, output int bc);
        int n = 0;
        bc = 0;
        while (!dn[i] && n < 100) begin
            bc += int'(bsy[i]);
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(dn[i]), 32'd1);
    endtask

    task automatic launch(input int i, input logic [31:0] x, input logic [31:0] y, input logic c);
        @(negedge clk);
        st[i] = 1'b1; av[i] = x; bv[i] = y; ci[i] = c;
        @(negedge clk);
        st[i] = 1'b0; av[i] = $urandom; bv[i] = $urandom; ci[i] = 1'($urandom);
    endtask

    task automatic op(input int i, input logic [31:0] x, input logic [31:0] y, input logic c,
                      input logic [31:0] es, input logic ec, input logic eo);
        int bc;
        launch(i, x, y, c);
        wait_done(i, bc);
        chk("sum", sm[i], es);
        chk("cout", 32'(co[i]), 32'(ec));
        chk("ovf", 32'(ov[i]), 32'(eo));
        chk("busy_cycles", bc, w[i]);
    endtask

    task automatic count_done(input int i, input int cyc, output int nd);
        nd = 0;
        repeat (cyc) begin
            @(negedge clk);
            nd += int'(dn[i]);
        end
    endtask

    task automatic rnd(input int i, input int num);
        logic [31:0] x, y;
        logic        c;
        logic [33:0] r;
        int          bc;
        for (int k = 0; k < num; k++) begin
            x = $urandom; y = $urandom; c = 1'($urandom);
            r = ref_add(w[i], x, y, c);
            launch(i, x, y, c);
            wait_done(i, bc);
            chk("rnd_sum", sm[i], r[31:0]);
            chk("rnd_cout_ovf", 32'({ov[i], co[i]}), 32'(r[33:32]));
        end
    endtask

    initial begin
        int nd, n;
        clk = 0; rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; av[i] = 0; bv[i] = 0; ci[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bsy[0]), 0);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_sum", sm[0], 0);
        chk("rst_flags", 32'({co[0], ov[0]}), 0);
        rst_n = 1;
        op(0, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0);
        op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        op(1, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1);
        op(1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0);
        op(1, 32'h12, 32'h34, 1'b1, 32'h47, 1'b0, 1'b0);
        // start pulsed mid-run must be ignored
        launch(0, 32'h0000_0003, 32'h0000_0004, 1'b0);
        repeat (5) @(negedge clk);
        st[0] = 1; av[0] = 32'hFFFF_FFFF; bv[0] = 32'h1; ci[0] = 1;
        @(negedge clk);
        st[0] = 0;
        wait_done(0, n);
        chk("busy_pulse_sum", sm[0], 32'h0000_0007);
        count_done(0, 40, nd);
        chk("busy_pulse_no_extra_done", nd, 0);
        // start held high: one result per 33 cycles
        @(negedge clk);
        st[0] = 1; av[0] = 32'h1234_5678; bv[0] = 32'h1111_1111; ci[0] = 1;
        count_done(0, 100, nd);
        chk("held_done_count", nd, 3);
        chk("held_sum", sm[0], 32'h2345_678A);
        st[0] = 0;
        n = 0;
        while (bsy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held_drain", 32'(bsy[0]), 0);
        // reset in the middle of a run
        launch(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", 32'(bsy[0]), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(bsy[0]), 0);
        chk("mid_rst_sum", sm[0], 0);
        chk("mid_rst_flags", 32'({dn[0], co[0], ov[0]}), 0);
        @(negedge clk);
        rst_n = 1;
        count_done(0, 40, nd);
        chk("aborted_no_done", nd, 0);
        op(0, 32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
        fork
            rnd(0, 1000);
            rnd(1, 1000);
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
